cell_sync_deglitch_evt: RTL and testbench
=========================================

// Module: cell_sync_deglitch_evt
// PURPOSE
//  Consumes the synchronized level from a 3-FF synchronizer in the same clock domain.
//  Rejects pulses shorter than FILT_CYC cycles and produces a filtered level.
//  Each filtered edge gives a one-cycle RISE/FALL pulse and is queued as a direction
//  event in a small FIFO, drained with a valid/ready handshake (status/IRQ logic).
// PARAMETERS
//  FILT_CYC  4  consecutive differing samples needed to accept a new level (1..255)
//  DEPTH     4  event FIFO depth; power of 2, 2..16
//  INIT      0  reset value of filtered level Q
// PORTS
//  CK        in   1              clock
//  RN        in   1              synchronous reset, active LOW
//  D         in   1              synchronized level (3-FF synchronizer output)
//  EN        in   1              filter enable; 0 = hold Q, qualify nothing
//  Q         out  1              filtered level
//  RISE      out  1              1-cycle pulse, Q went 0->1
//  FALL      out  1              1-cycle pulse, Q went 1->0
//  EVT_VLD   out  1              FIFO non-empty
//  EVT_RDY   in   1              consumer accepts head event
//  EVT_DIR   out  1              head event direction: 1 = rise, 0 = fall
//  EVT_CNT   out  $clog2(DEPTH+1) events held in FIFO
//  OVF       out  1              sticky: an event was dropped, FIFO full
//  OVF_CLR   in   1              clear OVF
// BEHAVIOUR
//  Reset (RN=0 at CK edge): Q=INIT, RISE=FALL=0, FIFO empty (EVT_VLD=0, EVT_CNT=0),
//   EVT_DIR=0, OVF=0, filter counter=0, FSM=STABLE. Applies mid-qualify and mid-drain;
//   partial qualification and queued events are discarded.
//  FSM, 8-bit counter cnt, evaluated each CK edge with EN=1:
//   STABLE : D==Q -> stay, cnt=0. D!=Q -> cnt=1; FILT_CYC==1 accepts on this edge,
//            else -> QUALIFY.
//   QUALIFY: D==Q -> STABLE, cnt=0 (glitch rejected, no event).
//            D!=Q -> cnt+1; when cnt+1==FILT_CYC: Q<=D, pulse, push, -> STABLE, cnt=0.
//  Latency: D first sampled different at edge k, held. Q, RISE/FALL update at edge
//   k+FILT_CYC-1. EVT_VLD rises the cycle after (FIFO has no fall-through).
//  EN=0: FSM forced STABLE, cnt=0, Q held, no pulses or pushes. FIFO keeps draining.
//  RISE/FALL: high exactly one cycle, registered, mutually exclusive.
//  FIFO: push on acceptance with data=new Q. Pop when EVT_VLD & EVT_RDY.
//   Head is EVT_DIR.
//   Empty: EVT_RDY ignored, EVT_DIR holds its last value.
//   Full + push + pop same edge: both performed, EVT_CNT stays DEPTH.
//   Full + push without pop: event dropped, OVF<=1, contents unchanged.
//   Pointers wrap modulo DEPTH. EVT_CNT = pushes - pops, never exceeds DEPTH.
//  OVF: set has priority over OVF_CLR on the same edge.
//   OVF_CLR alone clears it next edge.
//  All outputs registered; no combinational path from inputs to outputs.
// TESTING
//  FILT_CYC=4, D 0->1 held 10 cyc from edge 0 -> Q=1, RISE=1 after edge 3 only;
//   EVT_VLD=1, EVT_DIR=1, EVT_CNT=1 after edge 4.
//  D=1 for 3 cycles, then 0 -> Q stays 0, no RISE, EVT_CNT stays 0.
//   Repeat with FILT_CYC=1 -> Q follows D one edge later.
//  EVT_RDY=0, 5 accepted edges (r,f,r,f,r) -> EVT_CNT=4, OVF=1, drained order 1,0,1,0.
//   OVF_CLR -> OVF=0. OVF_CLR on same edge as a drop -> OVF stays 1.
//  FIFO full, EVT_RDY=1 on the accept edge -> EVT_CNT stays 4, OVF=0, new event is last out.
//  RN=0 at edge 2 of a FILT_CYC=4 qualify, then D held -> Q=INIT, FIFO empty.
//   Qualification restarts and accepts 4 edges after release.
//  EN=0 while D toggles slowly -> Q, RISE/FALL frozen, queued events still drain.
//   EN=1 with D!=Q -> accepted FILT_CYC edges later.

Source files
------------

// File: rtl/cell_sync_deglitch_evt.sv
// Deglitch filter for an already-synchronized level, with one-cycle edge pulses and a
// small event FIFO that queues the direction of every accepted edge.
module cell_sync_deglitch_evt #(
  parameter int unsigned FILT_CYC = 4,
  parameter int unsigned DEPTH    = 4,
  parameter bit          INIT     = 1'b0
) (
  input  logic                         CK,
  input  logic                         RN,
  input  logic                         D,
  input  logic                         EN,
  output logic                         Q,
  output logic                         RISE,
  output logic                         FALL,
  output logic                         EVT_VLD,
  input  logic                         EVT_RDY,
  output logic                         EVT_DIR,
  output logic [$clog2(DEPTH+1)-1:0]   EVT_CNT,
  output logic                         OVF,
  input  logic                         OVF_CLR
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW = $clog2(DEPTH);

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_QUALIFY = 1'b1;

  localparam logic [7:0]      FiltCyc = 8'(FILT_CYC);
  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Qualification filter
  // ---------------------------------------------------------------------------
  logic [0:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       q_q, q_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    accept  = 1'b0;
    if (EN) begin
      case (state_q)
        ST_STABLE: begin
          cnt_d = 8'd0;
          if (D != q_q) begin
            if (FiltCyc == 8'd1) begin
              accept = 1'b1;
            end else begin
              state_d = ST_QUALIFY;
              cnt_d   = 8'd1;
            end
          end
        end
        ST_QUALIFY: begin
          if (D == q_q) begin
            // Level returned before qualifying: treat it as a glitch.
            state_d = ST_STABLE;
            cnt_d   = 8'd0;
          end else if (cnt_q + 8'd1 == FiltCyc) begin
            accept  = 1'b1;
            state_d = ST_STABLE;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: begin
          state_d = ST_STABLE;
          cnt_d   = 8'd0;
        end
      endcase
      if (accept) begin
        q_d    = D;
        rise_d = D;
        fall_d = ~D;
      end
    end else begin
      state_d = ST_STABLE;
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q <= ST_STABLE;
      cnt_q   <= 8'd0;
      q_q     <= INIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO: the registered edge pulse is the push request, so an event
  // becomes visible one cycle after Q changes.
  // ---------------------------------------------------------------------------
  logic            mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] fcnt_q, fcnt_d;
  logic            dir_q, dir_d;
  logic            ovf_q, ovf_d;
  logic            push, push_dir, full, pop, wr_en, drop;

  always_comb begin
    push     = rise_q | fall_q;
    push_dir = rise_q;
    full     = (fcnt_q == DepthC);
    pop      = (fcnt_q != '0) & EVT_RDY;
    wr_en    = push & (~full | pop);
    drop     = push & full & ~pop;

    wr_ptr_d = wr_en ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    fcnt_d = fcnt_q;
    if (wr_en && !pop) begin
      fcnt_d = fcnt_q + CntW'(1);
    end else if (!wr_en && pop) begin
      fcnt_d = fcnt_q - CntW'(1);
    end

    // Registered head: bypass the write when the entry being written becomes the head.
    dir_d = dir_q;
    if (fcnt_d != '0) begin
      if (wr_en && (rd_ptr_d == wr_ptr_q)) begin
        dir_d = push_dir;
      end else begin
        dir_d = mem_q[rd_ptr_d];
      end
    end

    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CK) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_dir;
    end
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      dir_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      dir_q    <= dir_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Q       = q_q;
  assign RISE    = rise_q;
  assign FALL    = fall_q;
  assign EVT_VLD = (fcnt_q != '0);
  assign EVT_DIR = dir_q;
  assign EVT_CNT = fcnt_q;
  assign OVF     = ovf_q;

endmodule

// File: tb/tb_cell_sync_deglitch_evt.sv
// Directed bench for cell_sync_deglitch_evt; expected event directions are held in a
// scoreboard queue that also models the FIFO occupancy.
module tb_cell_sync_deglitch_evt;

  logic       CK = 1'b0;
  logic       RN, D, EN, EVT_RDY, OVF_CLR;
  logic       q, rise, fall, evt_vld, evt_dir, ovf;
  logic [2:0] evt_cnt;
  logic       q1, rise1, fall1, evt_vld1, evt_dir1, ovf1;
  logic [2:0] evt_cnt1;

  int n_tests = 0;
  int n_fail  = 0;
  bit exp_dirs[$];
  bit exp_ovf  = 1'b0;
  bit last_dir = 1'b0;

  cell_sync_deglitch_evt #(.FILT_CYC(4), .DEPTH(4), .INIT(1'b0)) dut (
    .CK(CK), .RN(RN), .D(D), .EN(EN), .Q(q), .RISE(rise), .FALL(fall),
    .EVT_VLD(evt_vld), .EVT_RDY(EVT_RDY), .EVT_DIR(evt_dir), .EVT_CNT(evt_cnt),
    .OVF(ovf), .OVF_CLR(OVF_CLR)
  );

  cell_sync_deglitch_evt #(.FILT_CYC(1), .DEPTH(4), .INIT(1'b0)) dut1 (
    .CK(CK), .RN(RN), .D(D), .EN(EN), .Q(q1), .RISE(rise1), .FALL(fall1),
    .EVT_VLD(evt_vld1), .EVT_RDY(1'b1), .EVT_DIR(evt_dir1), .EVT_CNT(evt_cnt1),
    .OVF(ovf1), .OVF_CLR(1'b0)
  );

  always #5 CK = ~CK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_fifo(input string tag);
    chk({tag, "_cnt"}, 32'(evt_cnt), 32'(exp_dirs.size()));
    chk({tag, "_vld"}, 32'(evt_vld), 32'(exp_dirs.size() != 0));
    chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    if (exp_dirs.size() != 0) chk({tag, "_dir"}, 32'(evt_dir), 32'(exp_dirs[0]));
  endtask

  // Drive D=v (Q currently !v) and walk through qualify, accept and push edges.
  task automatic accept_level(input bit v, input bit clr, input bit rdy);
    bit full, pop;
    D = v;
    step(3);
    chk("pre_q", 32'(q), 32'(!v));
    chk("pre_pulse", 32'(rise | fall), 32'd0);
    step(1);
    chk("acc_q", 32'(q), 32'(v));
    chk("acc_rise", 32'(rise), 32'(v));
    chk("acc_fall", 32'(fall), 32'(!v));
    full = (exp_dirs.size() == 4);
    pop  = rdy && (exp_dirs.size() != 0);
    EVT_RDY = rdy;
    OVF_CLR = clr;
    if (pop) begin
      chk("pop_dir", 32'(evt_dir), 32'(exp_dirs[0]));
      void'(exp_dirs.pop_front());
    end
    if (full && !pop) exp_ovf = 1'b1;
    else begin
      exp_dirs.push_back(v);
      if (clr) exp_ovf = 1'b0;
    end
    step(1);
    EVT_RDY = 1'b0;
    OVF_CLR = 1'b0;
    chk("push_pulse", 32'(rise | fall), 32'd0);
    chk_fifo("push");
  endtask

  task automatic drain_one();
    if (exp_dirs.size() != 0) begin
      chk("drain_vld", 32'(evt_vld), 32'd1);
      chk("drain_dir", 32'(evt_dir), 32'(exp_dirs[0]));
      last_dir = exp_dirs.pop_front();
      EVT_RDY = 1'b1;
      step(1);
      EVT_RDY = 1'b0;
      chk_fifo("drain");
      if (exp_dirs.size() == 0) chk("empty_dir_hold", 32'(evt_dir), 32'(last_dir));
    end
  endtask

  initial begin
    RN = 1'b0; EN = 1'b1; D = 1'b0; EVT_RDY = 1'b0; OVF_CLR = 1'b0;
    step(2);
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_pulse", 32'(rise | fall), 32'd0);
    chk("rst_dir", 32'(evt_dir), 32'd0);
    chk_fifo("rst");
    RN = 1'b1;

    // Short pulse rejected by the 4-cycle filter; the 1-cycle filter follows D.
    D = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("glitch_q", 32'(q), 32'd0);
      chk("glitch_rise", 32'(rise), 32'd0);
      chk("f1_q_hi", 32'(q1), 32'd1);
    end
    D = 1'b0;
    step(1);
    chk("f1_q_lo", 32'(q1), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("glitch_q_after", 32'(q), 32'd0);
      chk("glitch_pulse", 32'(rise | fall), 32'd0);
    end
    chk_fifo("glitch");

    // Latency: accept on the fourth edge, event visible one edge later.
    accept_level(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("hold_q", 32'(q), 32'd1);
      chk("hold_pulse", 32'(rise | fall), 32'd0);
    end
    drain_one();
    accept_level(1'b0, 1'b0, 1'b0);
    drain_one();

    // Overflow: five accepted edges with no consumer, then clear behaviour.
    accept_level(1'b1, 1'b0, 1'b0);
    accept_level(1'b0, 1'b0, 1'b0);
    accept_level(1'b1, 1'b0, 1'b0);
    accept_level(1'b0, 1'b0, 1'b0);
    chk("pre_ovf", 32'(ovf), 32'd0);
    accept_level(1'b1, 1'b0, 1'b0);
    OVF_CLR = 1'b1;
    exp_ovf = 1'b0;
    step(1);
    OVF_CLR = 1'b0;
    chk_fifo("ovf_clr");
    accept_level(1'b0, 1'b1, 1'b0);
    OVF_CLR = 1'b1;
    exp_ovf = 1'b0;
    step(1);
    OVF_CLR = 1'b0;
    chk_fifo("ovf_clr2");
    for (int i = 0; i < 4; i++) drain_one();

    // Full FIFO with a pop on the push edge: nothing dropped, new event last out.
    accept_level(1'b1, 1'b0, 1'b0);
    accept_level(1'b0, 1'b0, 1'b0);
    accept_level(1'b1, 1'b0, 1'b0);
    accept_level(1'b0, 1'b0, 1'b0);
    accept_level(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drain_one();

    // Reset mid-qualify with an event queued.
    accept_level(1'b0, 1'b0, 1'b0);
    D = 1'b1;
    step(2);
    RN = 1'b0;
    step(1);
    exp_dirs.delete();
    exp_ovf = 1'b0;
    chk("mid_rst_q", 32'(q), 32'd0);
    chk("mid_rst_pulse", 32'(rise | fall), 32'd0);
    chk("mid_rst_dir", 32'(evt_dir), 32'd0);
    chk_fifo("mid_rst");
    RN = 1'b1;
    step(3);
    chk("rst_requal_q", 32'(q), 32'd0);
    step(1);
    chk("rst_acc_q", 32'(q), 32'd1);
    chk("rst_acc_rise", 32'(rise), 32'd1);
    exp_dirs.push_back(1'b1);
    step(1);
    chk_fifo("rst_push");
    drain_one();

    // EN=0 freezes the filter while the FIFO keeps draining.
    accept_level(1'b0, 1'b0, 1'b0);
    EN = 1'b0;
    D = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) D = 1'b0;
      if (i == 9) D = 1'b1;
      step(1);
      chk("en0_q", 32'(q), 32'd0);
      chk("en0_pulse", 32'(rise | fall), 32'd0);
      if (i == 2) drain_one();
    end
    chk_fifo("en0");
    EN = 1'b1;
    step(3);
    chk("en1_pre_q", 32'(q), 32'd0);
    step(1);
    chk("en1_q", 32'(q), 32'd1);
    chk("en1_rise", 32'(rise), 32'd1);
    exp_dirs.push_back(1'b1);
    step(1);
    chk_fifo("en1_push");
    drain_one();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
